// File: rtl/serial_tx_word.sv
// Parallel-in, serial-out framed transmitter: start, WIDTH data bits LSB first, optional parity, stop.
// Frame occupies (2+WIDTH+PARITY_EN)*DIV cycles after the load edge; load is ignored while busy.
module serial_tx_word #(
  parameter int WIDTH      = 4,
  parameter int DIV        = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] I,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_par;
  logic [BW-1:0]    r_bit;
  logic [DW-1:0]    r_div;
  logic             r_so;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_bit   <= '0;
      r_div   <= '0;
      r_so    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_so   <= 1'b1;
          r_busy <= 1'b0;
          if (load) begin
            r_shreg <= I;
            r_par   <= (^I) ^ 1'(PARITY_ODD);
            r_state <= S_START;
            r_so    <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= '0;
            r_bit   <= '0;
          end
        end
        default: begin
          if (r_div != DIV_LAST) begin
            r_div <= r_div + DW'(1);
          end else begin
            r_div <= '0;
            case (r_state)
              S_START: begin
                r_state <= S_DATA;
                r_so    <= r_shreg[0];
                r_bit   <= '0;
              end
              S_DATA: begin
                if (r_bit == BIT_LAST) begin
                  if (PARITY_EN != 0) begin
                    r_state <= S_PARITY;
                    r_so    <= r_par;
                  end else begin
                    r_state <= S_STOP;
                    r_so    <= 1'b1;
                  end
                end else begin
                  // next LSB is bit 1 of the pre-shift value
                  r_shreg <= r_shreg >> 1;
                  r_so    <= r_shreg[1];
                  r_bit   <= r_bit + BW'(1);
                end
              end
              S_PARITY: begin
                r_state <= S_STOP;
                r_so    <= 1'b1;
              end
              default: begin
                r_state <= S_IDLE;
                r_so    <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign so   = r_so;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_tx_word.sv
// Bench for serial_tx_word: three instances (DIV=1 even, DIV=3 even, DIV=3 odd) share stimulus;
// expected per-cycle outputs are queued with a cycle tag and checked by an independent monitor.
module tb_serial_tx_word;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] I_in;
  logic [2:0] so_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;

  serial_tx_word #(.WIDTH(4), .DIV(1), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst(rst), .load(load), .I(I_in), .so(so_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  serial_tx_word #(.WIDTH(4), .DIV(3), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .load(load), .I(I_in), .so(so_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  serial_tx_word #(.WIDTH(4), .DIV(3), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .load(load), .I(I_in), .so(so_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  typedef struct {
    int    cyc;
    logic  so;
    logic  busy;
    logic  done;
    string nm;
  } exp_t;

  exp_t q[3][$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      while (q[d].size() > 0 && q[d][0].cyc <= cyc) begin
        mon_e = q[d].pop_front();
        n_tests++;
        if (mon_e.cyc < cyc) begin
          n_fail++;
          $display("FAIL %s dut%0d: check for cycle %0d not reached, now cycle %0d",
                   mon_e.nm, d, mon_e.cyc, cyc);
        end else if ({so_w[d], busy_w[d], done_w[d]} !== {mon_e.so, mon_e.busy, mon_e.done}) begin
          n_fail++;
          $display("FAIL %s dut%0d cycle %0d: so/busy/done got %b%b%b expected %b%b%b",
                   mon_e.nm, d, cyc, so_w[d], busy_w[d], done_w[d],
                   mon_e.so, mon_e.busy, mon_e.done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int d, int c, logic s, logic b, logic dn, string nm);
    exp_t e;
    e.cyc  = c;
    e.so   = s;
    e.busy = b;
    e.done = dn;
    e.nm   = nm;
    q[d].push_back(e);
  endtask

  task automatic exp_idle(int d, int c_from, int c_to, string nm);
    for (int c = c_from; c <= c_to; c++) push(d, c, 1'b1, 1'b0, 1'b0, nm);
  endtask

  // b[0] is the start bit, b[6] the stop bit; load accepted on edge c0+1
  task automatic exp_frame(int d, int div, int c0, logic [6:0] b, string nm);
    for (int k = 0; k < 7 * div; k++) push(d, c0 + 1 + k, b[k / div], 1'b1, 1'b0, nm);
    push(d, c0 + 1 + 7 * div, 1'b1, 1'b0, 1'b1, {nm, "_done"});
  endtask

  initial begin
    int c;
    rst  = 1'b0;
    load = 1'b0;
    I_in = 4'b0000;
    for (int d = 0; d < 3; d++) begin
      push(d, 1, 1'b1, 1'b0, 1'b0, "reset");
      push(d, 2, 1'b1, 1'b0, 1'b0, "reset");
    end
    tick();
    tick();
    rst = 1'b1;

    c = cyc;
    for (int d = 0; d < 3; d++) exp_idle(d, c + 1, c + 10, "idle");
    repeat (10) tick();

    c = cyc;
    load = 1'b1;
    I_in = 4'b1010;
    exp_frame(0, 1, c, 7'b1010100, "f1010_d1");
    exp_idle(0, c + 9, c + 10, "f1010_after");
    exp_frame(1, 3, c, 7'b1010100, "f1010_d3e");
    exp_frame(2, 3, c, 7'b1110100, "f1010_d3o");
    tick();
    load = 1'b0;
    repeat (24) tick();

    c = cyc;
    load = 1'b1;
    I_in = 4'b0111;
    exp_frame(0, 1, c, 7'b1101110, "f0111_d1");
    exp_frame(1, 3, c, 7'b1101110, "f0111_d3e");
    exp_frame(2, 3, c, 7'b1001110, "f0111_d3o");
    tick();
    load = 1'b0;
    repeat (24) tick();

    c = cyc;
    load = 1'b1;
    I_in = 4'b1111;
    exp_frame(0, 1, c, 7'b1011110, "busy_ign_d1");
    exp_idle(0, c + 9, c + 14, "busy_ign_nofr");
    exp_frame(1, 3, c, 7'b1011110, "busy_ign_d3e");
    exp_idle(1, c + 23, c + 26, "busy_ign_nofr");
    exp_frame(2, 3, c, 7'b1111110, "busy_ign_d3o");
    exp_idle(2, c + 23, c + 26, "busy_ign_nofr");
    tick();
    load = 1'b0;
    tick();
    load = 1'b1;
    I_in = 4'b0011;
    tick();
    load = 1'b0;
    repeat (26) tick();

    c = cyc;
    load = 1'b1;
    I_in = 4'b1010;
    exp_frame(0, 1, c, 7'b1010100, "b2b_first");
    exp_frame(0, 1, c + 8, 7'b1000110, "b2b_second");
    exp_idle(0, c + 17, c + 19, "b2b_after");
    exp_frame(1, 3, c, 7'b1010100, "b2b_d3e");
    exp_idle(1, c + 23, c + 24, "b2b_d3e_after");
    repeat (8) tick();
    I_in = 4'b0011;
    tick();
    load = 1'b0;
    repeat (20) tick();

    c = cyc;
    load = 1'b1;
    I_in = 4'b0101;
    push(0, c + 1, 1'b0, 1'b1, 1'b0, "rst_mid_start");
    push(0, c + 2, 1'b1, 1'b1, 1'b0, "rst_mid_d0");
    push(0, c + 3, 1'b1, 1'b0, 1'b0, "rst_mid_async");
    exp_idle(0, c + 4, c + 8, "rst_mid_nodone");
    push(1, c + 1, 1'b0, 1'b1, 1'b0, "rst_mid_start");
    push(1, c + 2, 1'b0, 1'b1, 1'b0, "rst_mid_start");
    exp_idle(1, c + 3, c + 8, "rst_mid_nodone");
    tick();
    load = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (3) tick();
    c = cyc;
    load = 1'b1;
    I_in = 4'b0011;
    exp_frame(0, 1, c, 7'b1000110, "post_rst_d1");
    exp_idle(0, c + 9, c + 10, "post_rst_after");
    exp_frame(1, 3, c, 7'b1000110, "post_rst_d3e");
    tick();
    load = 1'b0;
    repeat (26) tick();

    for (int d = 0; d < 3; d++) begin
      if (q[d].size() != 0) begin
        n_fail++;
        $display("FAIL drain dut%0d: %0d checks left unevaluated, expected 0", d, q[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
